// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: first-come-first-served arbiter for the 8-requester common bus.
// New requests are queued by arrival order; each grant is held until its owner drops req.
module com_bus_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] com_bus_req,
    output logic [NUM_REQ-1:0] com_bus_gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               bus_busy,
    output logic [ID_W-1:0]    queue_count
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] req_d, arr, pending, new_req, push_oh, clr;
    logic [ID_W-1:0]    q [NUM_REQ];
    logic [PW-1:0]      wr_ptr, rd_ptr, head_idx, own_idx, gnt_idx_n;
    logic [ID_W-1:0]    push_id, head, gnt_id_n;
    logic               push, pop;

    // Pending bits block re-entry, so each requester owns at most one queue slot.
    always_comb begin
        new_req = com_bus_req & ~req_d & ~pending;
        push    = |arr;
        push_oh = arr & (~arr + NUM_REQ'(1));
        push_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (arr[i]) push_id = ID_W'(i + 1);
        head      = q[rd_ptr];
        head_idx  = PW'(head - ID_W'(1));
        own_idx   = PW'(gnt_id - ID_W'(1));
    end

    always_comb begin
        state_n  = state;
        gnt_id_n = gnt_id;
        pop      = 1'b0;
        clr      = '0;
        if (state == GRANT) begin
            if (!com_bus_req[own_idx]) begin
                gnt_id_n     = '0;
                clr[own_idx] = 1'b1;
                state_n      = RELEASE;
            end
        end else if (queue_count != '0) begin
            pop = 1'b1;
            if (com_bus_req[head_idx]) begin
                gnt_id_n = head;
                state_n  = GRANT;
            end else begin
                clr[head_idx] = 1'b1;
                state_n       = IDLE;
            end
        end else begin
            state_n = IDLE;
        end
        gnt_idx_n = PW'(gnt_id_n - ID_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_d       <= '0;
            arr         <= '0;
            pending     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            gnt_id      <= '0;
            com_bus_gnt <= '0;
            bus_busy    <= 1'b0;
        end else begin
            state       <= state_n;
            req_d       <= com_bus_req;
            arr         <= (arr | new_req) & ~push_oh;
            pending     <= (pending | new_req) & ~clr;
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr + PW'(pop);
            queue_count <= queue_count + ID_W'(push) - ID_W'(pop);
            gnt_id      <= gnt_id_n;
            com_bus_gnt <= (gnt_id_n != '0) ? NUM_REQ'(1) << gnt_idx_n : '0;
            bus_busy    <= gnt_id_n != '0;
        end
    end

    always_ff @(posedge clk)
        if (push) q[wr_ptr] <= push_id;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: directed and randomized checks of com_bus_arbiter against a queue-based model.
module tb_com_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] com_bus_req;
    logic [7:0] com_bus_gnt;
    logic [3:0] gnt_id;
    logic       bus_busy;
    logic [3:0] queue_count;

    int errs = 0;
    int checks = 0;

    int         mq[$];
    logic [7:0] m_pend, m_arr, m_reqd;
    int         m_own, m_ph;

    com_bus_arbiter dut (
        .clk(clk),
        .rst(rst),
        .com_bus_req(com_bus_req),
        .com_bus_gnt(com_bus_gnt),
        .gnt_id(gnt_id),
        .bus_busy(bus_busy),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pend = '0;
        m_arr  = '0;
        m_reqd = '0;
        m_own  = 0;
        m_ph   = 0;
    endtask

    // Phase: 0 idle, 1 bus owned, 2 turnaround after a release.
    task automatic m_step(input logic [7:0] r);
        logic [7:0] nw;
        int pid, h;
        nw  = r & ~m_reqd & ~m_pend;
        pid = 0;
        for (int i = 7; i >= 0; i--) if (m_arr[i]) pid = i + 1;
        if (m_ph == 1) begin
            if (!r[m_own-1]) begin
                m_pend[m_own-1] = 1'b0;
                m_own = 0;
                m_ph  = 2;
            end
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (r[h-1]) begin
                m_own = h;
                m_ph  = 1;
            end else begin
                m_pend[h-1] = 1'b0;
                m_ph = 0;
            end
        end else begin
            m_ph = 0;
        end
        if (pid != 0) begin
            mq.push_back(pid);
            m_arr[pid-1] = 1'b0;
        end
        m_arr  |= nw;
        m_pend |= nw;
        m_reqd  = r;
    endtask

    task automatic cmp_model();
        logic [7:0] eg;
        eg = (m_own != 0) ? 8'(1) << (m_own - 1) : 8'h00;
        chk("gnt", com_bus_gnt, eg);
        chk("gnt_id", gnt_id, m_own);
        chk("bus_busy", bus_busy, m_own != 0);
        chk("queue_count", queue_count, mq.size());
    endtask

    task automatic cyc(input logic [7:0] r);
        com_bus_req = r;
        @(posedge clk);
        m_step(r);
        #1 cmp_model();
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b0;
        com_bus_req = '0;
        m_reset();
        #3;
        chk("rst_gnt", com_bus_gnt, 8'h00);
        chk("rst_gnt_id", gnt_id, 4'd0);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_count", queue_count, 4'd0);
        #8 rst = 1'b1;
        cyc(8'h00);
        cyc(8'h00);
        // Single request on requester 2.
        cyc(8'h04);
        cyc(8'h04);
        chk("single_q1", queue_count, 4'd1);
        cyc(8'h04);
        chk("single_gnt", com_bus_gnt, 8'h04);
        chk("single_id", gnt_id, 4'd3);
        chk("single_busy", bus_busy, 1'b1);
        chk("single_q0", queue_count, 4'd0);
        repeat (3) cyc(8'h04);
        cyc(8'h00);
        chk("single_drop", com_bus_gnt, 8'h00);
        chk("single_idle", bus_busy, 1'b0);
        cyc(8'h00);
        // Requester 0 owns the bus, then everyone raises req together.
        repeat (3) cyc(8'h01);
        chk("own0_gnt", com_bus_gnt, 8'h01);
        repeat (8) cyc(8'hff);
        chk("all8_count", queue_count, 4'd7);
        // Asynchronous reset while requester 0 holds the grant.
        #2 rst = 1'b0;
        #1;
        chk("arst_gnt", com_bus_gnt, 8'h00);
        chk("arst_id", gnt_id, 4'd0);
        chk("arst_busy", bus_busy, 1'b0);
        chk("arst_count", queue_count, 4'd0);
        m_reset();
        #2;
        com_bus_req = 8'h10;
        rst = 1'b1;
        cyc(8'h10);
        cyc(8'h10);
        cyc(8'h10);
        chk("arst_regnt", com_bus_gnt, 8'h10);
        // Simultaneous arrivals and withdrawals behind an active owner.
        cyc(8'h91);
        repeat (6) cyc(8'h91);
        repeat (4) cyc(8'h81);
        repeat (6) cyc(8'h80);
        repeat (3) cyc(8'h00);
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            r ^= 8'($urandom & $urandom & $urandom);
            cyc(r);
        end
        repeat (20) cyc(8'h00);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/com_bus_arbiter.md
# com_bus_arbiter

First-come-first-served arbiter for the 8-requester common bus of the 4-core system. It detects new bus requests, records their arrival order in an internal 8-entry ID queue, and grants the bus to one requester at a time. It holds each grant until the owner drops its request, then hands the bus to the next queued requester. It replaces the free-running grant-order logger with a fully synchronous, single-clock scheduler.

## Interface
- NUM_REQ, 8, number of requesters; fixed at 8 for ID encoding.
- ID_W, 4, width of requester ID; IDs 1..8, 0 = none.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous and active-low.
- com_bus_req  input  8  level request per requester; bit i = requester i.
- com_bus_gnt  output  8  one-hot grant; at most one bit set.
- gnt_id  output  4  granted requester as i+1; 0 when no grant.
- bus_busy  output  1  high while any grant is asserted.
- queue_count  output  4  queue occupancy, 0..8.

## Operation
- Reset (rst=0, async) clears the following immediately:
  - com_bus_gnt=0, gnt_id=0, bus_busy=0, queue_count=0.
  - Read and write pointers = 0.
  - Arrival mask, pending mask and req_d = 0.
  - State = IDLE.
- Edge detect: req_d registers com_bus_req each cycle. new = com_bus_req & ~req_d & ~pending.
- Arrival mask arr: arr <= (arr | new) minus the bit enqueued this cycle. The pending bit is set for every bit captured into arr.
- Enqueue: when arr≠0, push the lowest-index set bit's ID (i+1) into the queue. This is one push per cycle. Simultaneous arrivals are therefore ordered lowest index first.
- Pending bit i is cleared only when requester i is released from GRANT or discarded at pop.
- Because pending blocks re-entry, each requester has at most one entry. Depth 8 can therefore never overflow, and no full stall is needed.
- State machine IDLE / GRANT / RELEASE:
  - IDLE: if queue_count>0, pop the head.
    - If the head requester's com_bus_req is high: set its com_bus_gnt bit and gnt_id, then go to GRANT.
    - If it is low (request withdrawn while queued): discard it, clear its pending bit, stay IDLE. Each discard costs one cycle.
  - GRANT: hold the grant while the owner's req is sampled high. When it is sampled low: clear com_bus_gnt and gnt_id, clear the owner's pending bit, go to RELEASE. There is no timeout or preemption.
  - RELEASE: one-cycle bus turnaround with no grant. Then apply the IDLE pop rule directly from RELEASE (pop/grant or discard), or go to IDLE if the queue is empty.
- Pointers are 3-bit and wrap 7→0. queue_count is 4-bit. If a push and a pop occur in the same cycle, the count is unchanged.
- A requester that drops and re-raises req while still pending is not re-enqueued; its existing entry serves it.
- bus_busy = |com_bus_gnt, driven from registered state.

## Timing
- All outputs are registered; none are combinational from com_bus_req.
- Request sampled high at edge E0 with an empty queue and IDLE state:
  - Queued at E0+1 (queue_count=1).
  - Granted at E0+2 (queue_count=0).
- Owner req sampled low at edge R: grant drops at R. The next queued requester is granted at R+1 at the earliest, giving exactly one dead cycle.
- Assertion of rst mid-grant drops com_bus_gnt asynchronously. On rst release, requests already high are treated as new at the first sampling edge, since req_d=0.

## Test plan
- Single request: req[2] high at E0 and held 5 cycles, then low.
  - gnt=8'h04, gnt_id=3 from E0+2; queue_count=1 at E0+1.
  - Grant drops the edge req is sampled low; bus_busy tracks the grant.
- Simultaneous arrival: req=8'h91 at E0.
  - Queue order IDs 1, 5, 8; queue_count reaches 3 at E0+3.
  - Grants in order 0 → 4 → 7, each with one dead cycle after release.
- FCFS across cycles: req[6] at E0, req[1] at E0+1, with req[6] holding the bus 10 cycles.
  - Grant order is 6 then 1, even though 1 has the lower index.
- Withdrawn request: req[3] and req[5] queued behind an active owner; req[3] dropped before its turn.
  - At release, ID 4 is discarded (queue_count decrements, no grant).
  - gnt=8'h20 one cycle after a grant would have been given to ID 4.
- All 8 requesters raised together while req[0] is already granted.
  - queue_count saturates at 7 (0 is pending); no duplicate entries.
  - Pointers wrap correctly over two full rounds.
- Reset mid-grant with rst=0 asynchronously.
  - All outputs are 0 before the next clock edge.
  - After release with req[4] still high: gnt=8'h10 at the 3rd edge.
